// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-memory arbiter: widths, FSM states and client ids.
package mem_if_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic CL_I = 1'b0;
    localparam logic CL_D = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser; the last-grant bit is held by the caller.
module rr_pick2
    import mem_if_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant
);

    // On contention the client that did not win last time goes next;
    // otherwise the lone requester wins (result is meaningless with no request).
    always_comb begin
        grant = CL_I;
        if (req_i && req_d) begin
            grant = ~last_grant;
        end else if (req_d) begin
            grant = CL_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between I-cache and D-cache for a single shared slow memory.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    import mem_if_pkg::*;

    state_t state;
    logic   last_grant;
    logic   req_i;
    logic   req_d;
    logic   grant;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

    rr_pick2 u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign i_ready = mem_ready && (state == BUSY_I);
    assign d_ready = mem_ready && (state == BUSY_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= CL_D;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i || req_d) begin
                        last_grant <= grant;
                        // Write wins over read if a client illegally raises both.
                        if (grant == CL_D) begin
                            state     <= BUSY_D;
                            mem_write <= d_write;
                            mem_read  <= d_read & ~d_write;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            state     <= BUSY_I;
                            mem_write <= i_write;
                            mem_read  <= i_read & ~i_write;
                            mem_addr  <= i_addr;
                            mem_wdata <= i_wdata;
                        end
                    end else begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Client inputs in the ready cycle are stale; the forced IDLE
                    // cycle guarantees a gap before the next grant is sampled.
                    if (mem_ready) begin
                        state     <= IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(i_read && i_write)) else $warning("i-cache raised read and write together");
            assert (!(d_read && d_write)) else $warning("d-cache raised read and write together");
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: table-driven sequence plus hand-written corner cases.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    localparam logic [AW-1:0] IA   = 28'h0000010;
    localparam logic [AW-1:0] DA   = 28'h0000020;
    localparam logic [DW-1:0] IWD  = {4{32'h1111_2222}};
    localparam logic [DW-1:0] DWD  = {4{32'hDDDD_0001}};
    localparam logic [DW-1:0] DWD2 = {4{32'hBEEF_0123}};
    localparam logic [DW-1:0] RD   = {16{8'hA5}};

    logic          clk;
    logic          rst_n;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] i_wdata, d_wdata;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          i_ready, d_ready;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    int checks = 0;
    int errors = 0;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_write   (i_write),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ir, iw, dr, dw, mrdy;
        logic          e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_ir, e_dr;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic ir, iw, dr, dw, mrdy, e_rd, e_wr,
                                input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wd,
                                input logic e_ir, e_dr);
        vec_t v;
        v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.mrdy = mrdy;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_ir = e_ir; v.e_dr = e_dr;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_read = 0; i_write = 0; d_read = 0; d_write = 0; mem_ready = 0;
    endtask

    initial begin
        // Row: inputs for this cycle, then the outputs expected in the same cycle
        // (mem_* reflect the previous edge, readies are combinational).
        vecs[0]  = mk(0,0,0,0,0, 0,0,'0,'0,  0,0);
        vecs[1]  = mk(1,0,0,1,0, 0,0,'0,'0,  0,0);
        vecs[2]  = mk(1,0,0,1,0, 1,0,IA,IWD, 0,0);
        vecs[3]  = mk(1,0,0,1,0, 1,0,IA,IWD, 0,0);
        vecs[4]  = mk(1,0,0,1,1, 1,0,IA,IWD, 1,0);
        vecs[5]  = mk(1,0,0,1,0, 0,0,IA,IWD, 0,0);
        vecs[6]  = mk(1,0,0,1,1, 0,1,DA,DWD, 0,1);
        vecs[7]  = mk(1,0,0,1,0, 0,0,DA,DWD, 0,0);
        vecs[8]  = mk(1,0,0,1,1, 1,0,IA,IWD, 1,0);
        vecs[9]  = mk(1,0,0,1,0, 0,0,IA,IWD, 0,0);
        vecs[10] = mk(1,0,0,1,1, 0,1,DA,DWD, 0,1);
        vecs[11] = mk(0,0,0,0,1, 0,0,DA,DWD, 0,0);
        vecs[12] = mk(0,0,0,0,0, 0,0,DA,DWD, 0,0);

        rst_n = 0;
        idle_inputs();
        i_addr = IA; d_addr = DA; i_wdata = IWD; d_wdata = DWD; mem_rdata = RD;
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            i_read = vecs[k].ir; i_write = vecs[k].iw;
            d_read = vecs[k].dr; d_write = vecs[k].dw;
            mem_ready = vecs[k].mrdy;
            #1;
            check($sformatf("vec%0d mem_read", k),  DW'(mem_read),  DW'(vecs[k].e_rd));
            check($sformatf("vec%0d mem_write", k), DW'(mem_write), DW'(vecs[k].e_wr));
            check($sformatf("vec%0d mem_addr", k),  DW'(mem_addr),  DW'(vecs[k].e_addr));
            check($sformatf("vec%0d mem_wdata", k), mem_wdata,      vecs[k].e_wd);
            check($sformatf("vec%0d i_ready", k),   DW'(i_ready),   DW'(vecs[k].e_ir));
            check($sformatf("vec%0d d_ready", k),   DW'(d_ready),   DW'(vecs[k].e_dr));
            if (vecs[k].e_ir) check($sformatf("vec%0d i_rdata", k), i_rdata, RD);
            if (vecs[k].e_dr) check($sformatf("vec%0d d_rdata", k), d_rdata, RD);
        end

        // Write-back then refill: the new read is presented in the ready cycle itself.
        @(negedge clk);
        idle_inputs();
        d_write = 1; d_addr = 28'h0000123; d_wdata = DWD2;
        @(negedge clk); #1;
        check("wb mem_write", DW'(mem_write), DW'(1'b1));
        check("wb mem_addr", DW'(mem_addr), DW'(28'h0000123));
        check("wb mem_wdata", mem_wdata, DWD2);
        d_write = 0; d_read = 1; d_addr = 28'h0000456; mem_ready = 1;
        #1;
        check("wb d_ready", DW'(d_ready), DW'(1'b1));
        @(negedge clk);
        mem_ready = 0; #1;
        check("gap mem_write", DW'(mem_write), DW'(1'b0));
        check("gap mem_read", DW'(mem_read), DW'(1'b0));
        @(negedge clk); #1;
        check("refill mem_read", DW'(mem_read), DW'(1'b1));
        check("refill mem_write", DW'(mem_write), DW'(1'b0));
        check("refill mem_addr", DW'(mem_addr), DW'(28'h0000456));
        mem_ready = 1;
        @(negedge clk);
        idle_inputs();

        // Illegal read+write from I: write is forwarded.
        i_read = 1; i_write = 1; i_addr = 28'h0000077;
        @(negedge clk); #1;
        check("illegal mem_write", DW'(mem_write), DW'(1'b1));
        check("illegal mem_read", DW'(mem_read), DW'(1'b0));
        check("illegal mem_addr", DW'(mem_addr), DW'(28'h0000077));
        i_read = 0; i_write = 0; mem_ready = 1;
        #1;
        check("illegal i_ready", DW'(i_ready), DW'(1'b1));
        @(negedge clk);
        idle_inputs();

        // Asynchronous reset in the middle of a D read.
        d_read = 1; d_addr = 28'h0000099;
        @(negedge clk); #1;
        check("pre-rst mem_read", DW'(mem_read), DW'(1'b1));
        check("pre-rst d_addr", DW'(mem_addr), DW'(28'h0000099));
        @(posedge clk); #2;
        rst_n = 0; #1;
        check("rst mem_read", DW'(mem_read), DW'(1'b0));
        check("rst mem_write", DW'(mem_write), DW'(1'b0));
        check("rst mem_addr", DW'(mem_addr), DW'(0));
        check("rst mem_wdata", mem_wdata, DW'(0));
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        mem_ready = 1; #1;
        check("stray i_ready", DW'(i_ready), DW'(1'b0));
        check("stray d_ready", DW'(d_ready), DW'(1'b0));
        @(negedge clk);
        mem_ready = 0; #1;
        check("post-rst idle mem_read", DW'(mem_read), DW'(1'b0));

        // After reset the I-cache wins the first tie.
        i_read = 1; i_addr = IA; d_write = 1; d_addr = DA; d_wdata = DWD;
        @(negedge clk); #1;
        check("tie mem_read", DW'(mem_read), DW'(1'b1));
        check("tie mem_write", DW'(mem_write), DW'(1'b0));
        check("tie mem_addr", DW'(mem_addr), DW'(IA));
        mem_ready = 1; #1;
        check("tie d_ready", DW'(d_ready), DW'(1'b0));
        @(negedge clk);
        idle_inputs();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
